// File: rtl/fifo_burst_reader.sv
// Burst reader: pops len words from a synchronous FIFO through a 2-entry
// skid buffer onto a valid/ready stream, then pulses done.
// Ports: clk, rst_n, start, len, busy, done, fifo_rd_en, fifo_rd_data,
// fifo_empty, m_valid, m_data, m_last, m_ready
// (+ xfer_cnt when FIFO_BURST_READER_CNT_EN is defined).
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
`ifdef FIFO_BURST_READER_CNT_EN
  ,
  output logic [15:0]           xfer_cnt
`endif
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DONE
  } state_t;

  state_t                state;
  logic [CW-1:0]         pop_cnt;
  logic [CW-1:0]         send_cnt;
  logic [1:0]            occ;
  logic                  in_flight;
  logic [DATA_WIDTH-1:0] b0;
  logic [DATA_WIDTH-1:0] b1;
  logic                  xfer;
  logic [1:0]            slots;

  assign m_valid = (occ != 2'd0);
  assign m_data  = b0;
  assign m_last  = m_valid && (send_cnt == ONE);
  assign xfer    = m_valid && m_ready;

  // Slots claimed once this cycle's transfer leaves: lets a pop overlap
  // a drain so the stream sustains one word per cycle.
  assign slots = occ - {1'b0, xfer} + {1'b0, in_flight};

  assign fifo_rd_en = (state == READ) && (pop_cnt != '0)
                   && !fifo_empty && (slots < 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pop_cnt   <= '0;
      send_cnt  <= '0;
      occ       <= 2'd0;
      in_flight <= 1'b0;
      b0        <= '0;
      b1        <= '0;
    end else begin
      in_flight <= fifo_rd_en;
      if (fifo_rd_en && pop_cnt != '0)
        pop_cnt <= pop_cnt - ONE;
      if (xfer && send_cnt != '0)
        send_cnt <= send_cnt - ONE;

      // Skid buffer: b0 is the head, b1 the second entry.
      if (in_flight && xfer) begin
        if (occ == 2'd2) begin
          b0 <= b1;
          b1 <= fifo_rd_data;
        end else begin
          b0 <= fifo_rd_data;
        end
      end else if (in_flight) begin
        if (occ == 2'd0) b0 <= fifo_rd_data;
        else             b1 <= fifo_rd_data;
        occ <= occ + 2'd1;
      end else if (xfer) begin
        b0  <= b1;
        occ <= occ - 2'd1;
      end

      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (len != '0) begin
              pop_cnt  <= len;
              send_cnt <= len;
              busy     <= 1'b1;
              state    <= READ;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        READ: begin
          if (xfer && m_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_BURST_READER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      xfer_cnt <= 16'd0;
    else if (xfer)
      xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, FIFO word width; ADDR_WIDTH, default 3, FIFO address width, so depth is 2**ADDR_WIDTH and burst length is ADDR_WIDTH+1 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 start  input  1  burst request, sampled on a rising edge of clk.
REQ-005 len  input  ADDR_WIDTH+1  number of words in the burst, sampled with start, legal range 0..2**ADDR_WIDTH.
REQ-006 busy  output  1  burst in progress.
REQ-007 done  output  1  one-cycle pulse marking burst completion.
REQ-008 fifo_rd_en  output  1  pop request to the synchronous FIFO.
REQ-009 fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid on the cycle after fifo_rd_en.
REQ-010 fifo_empty  input  1  FIFO empty flag.
REQ-011 m_valid  output  1  output word valid.
REQ-012 m_data  output  DATA_WIDTH  output word.
REQ-013 m_last  output  1  marks the final word of the burst and is qualified by m_valid.
REQ-014 m_ready  input  1  downstream accept; a transfer occurs when m_valid and m_ready are both 1 on a clk edge.

Function
REQ-015 The state machine SHALL have three states: IDLE, READ and DONE.
REQ-016 In IDLE, when start=1 and len>0 on a clk edge, the block SHALL latch len into a remaining-to-pop counter and a remaining-to-send counter, then enter READ; busy=1 from the next cycle.
REQ-017 In IDLE, when start=1 and len=0, the block SHALL enter DONE directly and issue no FIFO reads.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 fifo_rd_en SHALL be combinational and equal to 1 only when all of the following hold:
  - state is READ
  - remaining-to-pop > 0
  - fifo_empty = 0
  - occupancy + in-flight < 2
  Here occupancy is the number of skid-buffer entries, 0..2, and in-flight is a pop issued in the previous cycle.
REQ-020 The word returned by a pop SHALL be written into a 2-entry skid buffer on the next clk edge; remaining-to-pop SHALL decrement on each pop.
REQ-021 m_valid SHALL equal (occupancy > 0), and m_data SHALL be the oldest buffered word, in FIFO order.
REQ-022 m_last SHALL be 1 exactly when m_valid=1 and remaining-to-send=1.
REQ-023 Each transfer SHALL decrement remaining-to-send; a pop-capture and a transfer in the same cycle SHALL leave occupancy unchanged.
REQ-024 Latency: with fifo_empty=0 and m_ready=1, the first m_valid SHALL assert 2 cycles after the start edge, and sustained throughput SHALL be 1 word per cycle.
REQ-025 When m_ready=0, the buffer SHALL hold its data, and m_data/m_last SHALL stay stable while m_valid=1.
REQ-026 If fifo_empty=1 mid-burst, popping SHALL stall with no underflow read and resume when fifo_empty=0.
REQ-027 On the transfer of the m_last word, the state SHALL go to DONE.
REQ-028 In DONE, done=1 and busy=0 for exactly one cycle, then the state SHALL return to IDLE.
REQ-029 A start in the DONE cycle SHALL be ignored.
REQ-030 Counter arithmetic SHALL be unsigned at ADDR_WIDTH+1 bits and SHALL never wrap below 0.

Reset
REQ-031 While rst_n=0, the block SHALL immediately force:
  - state = IDLE
  - busy = 0, done = 0, fifo_rd_en = 0
  - m_valid = 0, m_last = 0
  - m_data = 0, occupancy = 0, in-flight = 0, both counters = 0
REQ-032 A reset asserted mid-burst SHALL discard buffered and in-flight words; the block SHALL resume in IDLE on the first edge after rst_n=1.

Configuration
REQ-033 With macro FIFO_BURST_READER_CNT_EN defined, the block SHALL add output xfer_cnt, 16 bits, reset 0, which increments on every m_valid&&m_ready transfer and wraps from 65535 to 0.
REQ-034 Without FIFO_BURST_READER_CNT_EN, the xfer_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-035 FIFO preloaded with 1..8, start with len=8, m_ready=1 -> m_data 1..8 on 8 consecutive cycles starting 2 cycles after start, m_last with 8, done pulse the cycle after.
REQ-036 FIFO preloaded with 1..4, len=4, m_ready toggling 1,0,1,0 -> words 1..4 delivered in order, no loss or duplication, data stable while stalled, at most 2 pops ahead of transfers.
REQ-037 FIFO empty, len=3, then 3 words pushed 5 cycles later -> fifo_rd_en stays 0 while empty, words delivered after pushes, done after the third transfer.
REQ-038 len=0 -> done=1 one cycle after start, fifo_rd_en never asserted, m_valid stays 0.
REQ-039 rst_n pulsed low after 2 of 6 words transferred -> all outputs 0 immediately; a new len=2 burst afterward returns the next 2 FIFO words.
REQ-040 With FIFO_BURST_READER_CNT_EN, two bursts of 8 and 3 -> xfer_cnt=11; a second start while busy -> ignored, counts unaffected.
